// File: rtl/tt_um_ay5876_pattern_generator_pkg.sv
// Shared constants and state encoding for the serial pattern generator.
// The ui_in bit positions are kept here so the driver and the detectors agree on them.
package tt_um_ay5876_pattern_generator_pkg;

    localparam int PAT_W      = 8;
    localparam int LEN_W      = 3;
    localparam int START_BIT  = 3;
    localparam int REPEAT_BIT = 4;
    localparam int ABORT_BIT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/tt_um_ay5876_pattern_generator_if.sv
// Tiny Tapeout style pin bundle between a driver (master) and the generator (slave).
interface tt_um_ay5876_pattern_generator_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/tt_um_ay5876_pattern_generator_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Holding clear keeps the count at 0 so the first bit after release gets a full period.
module pattern_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_ay5876_pattern_generator.sv
// Serial test-pattern transmitter: shifts a 1..8 bit pattern MSB-first on uo_out[0],
// once or back-to-back, with abort and a one-cycle done pulse.
module tt_um_ay5876_pattern_generator
    import tt_um_ay5876_pattern_generator_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    tt_um_ay5876_pattern_generator_if.slave       tt
);

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [LEN_W-1:0]  last_idx_q, last_idx_d;
    logic [LEN_W-1:0]  bit_idx_q, bit_idx_d;
    logic              start_q;

    logic              start_pulse;
    logic              rep;
    logic              abort;
    logic              tick;
    logic              timer_clear;

    assign start_pulse = tt.ui_in[START_BIT] & ~start_q;
    assign rep         = tt.ui_in[REPEAT_BIT];
    assign abort       = tt.ui_in[ABORT_BIT];
    assign timer_clear = (state_q != ST_SEND);

    pattern_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .tick  (tick)
    );

    // The stored length is kept as len-1 so it doubles as the first bit index.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        last_idx_d = last_idx_q;
        bit_idx_d  = bit_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_pulse && !abort) begin
                    state_d    = ST_SEND;
                    pattern_d  = tt.uio_in;
                    last_idx_d = tt.ui_in[LEN_W-1:0];
                    bit_idx_d  = tt.ui_in[LEN_W-1:0];
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (bit_idx_q == '0) begin
                        if (rep) begin
                            bit_idx_d = last_idx_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pattern_q  <= '0;
            last_idx_q <= '0;
            bit_idx_q  <= '0;
            start_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            last_idx_q <= last_idx_d;
            bit_idx_q  <= bit_idx_d;
            start_q    <= tt.ui_in[START_BIT];
        end
    end

    logic             sending;
    logic             tx;
    logic [LEN_W-1:0] idx_out;

    assign sending = (state_q == ST_SEND);
    assign tx      = sending & pattern_q[bit_idx_q];
    assign idx_out = sending ? bit_idx_q : '0;

    assign tt.uo_out  = {1'b0, sending & rep, idx_out, (state_q == ST_DONE), sending, tx};
    assign tt.uio_out = '0;
    assign tt.uio_oe  = '0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, tt.ena, tt.ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_ay5876_pattern_generator.sv
// Bench for the pattern generator: two instances (1 and 3 clocks per bit) share stimulus
// and are checked every cycle against an elapsed-time model, plus literal waveform checks.
module tb_tt_um_ay5876_pattern_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;

    always #5 clk = ~clk;

    tt_um_ay5876_pattern_generator_if if1 ();
    tt_um_ay5876_pattern_generator_if if3 ();

    assign if1.ena    = 1'b1;
    assign if1.ui_in  = ui_in;
    assign if1.uio_in = uio_in;
    assign if3.ena    = 1'b1;
    assign if3.ui_in  = ui_in;
    assign if3.uio_in = uio_in;

    tt_um_ay5876_pattern_generator #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (if1)
    );

    tt_um_ay5876_pattern_generator #(.CLKS_PER_BIT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (if3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is described only by its pattern, length and cycles elapsed in the pass.
    int   cpb [2] = '{1, 3};
    int   m_state [2];   // 0 idle, 1 sending, 2 done
    int   m_pat [2];
    int   m_len [2];
    int   m_el [2];
    logic m_prev [2];
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic sp;
            sp = ui_in[3] & ~m_prev[k];
            m_prev[k] = ui_in[3];
            if (!rst_n) begin
                m_state[k] = 0;
                m_prev[k]  = 1'b1;
                m_el[k]    = 0;
            end else begin
                case (m_state[k])
                    0: if (sp && !ui_in[5]) begin
                        m_state[k] = 1;
                        m_pat[k]   = int'(uio_in);
                        m_len[k]   = int'(ui_in[2:0]) + 1;
                        m_el[k]    = 0;
                    end
                    1: if (ui_in[5]) begin
                        m_state[k] = 0;
                    end else begin
                        m_el[k]++;
                        if (m_el[k] == m_len[k] * cpb[k]) begin
                            if (ui_in[4]) m_el[k] = 0;
                            else          m_state[k] = 2;
                        end
                    end
                    default: m_state[k] = 0;
                endcase
            end
        end
        if (!rst_n) m_valid = 1'b1;
    end

    function automatic logic [7:0] exp_uo(input int k);
        int         idx;
        logic [2:0] idx3;
        logic       tx;
        if (m_state[k] == 1) begin
            idx  = m_len[k] - 1 - m_el[k] / cpb[k];
            idx3 = idx[2:0];
            tx   = ((m_pat[k] >> idx) & 1) != 0;
            return {1'b0, ui_in[4], idx3, 1'b0, 1'b1, tx};
        end else if (m_state[k] == 2) begin
            return 8'h04;
        end
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        #1;
        if (m_valid) begin
            chk("uo_out_cpb1", if1.uo_out, exp_uo(0));
            chk("uo_out_cpb3", if3.uo_out, exp_uo(1));
            chk("uio_tied", {if1.uio_out, if1.uio_oe, if3.uio_out, if3.uio_oe}, 32'h0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0]  seq4;
        logic [15:0] seq16;
        logic [11:0] seq12;
        int          cnt;
        int          dc;

        // T1: start held high through reset must not fire
        ui_in = 8'h08; uio_in = 8'h00; rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            cnt += int'(if1.uo_out != 8'h00) + int'(if3.uo_out != 8'h00);
        end
        chk("t1_idle_after_reset", cnt, 0);
        $display("[t1] reset with start high: nonzero outputs seen %0d", cnt);

        // T2: 0x0D len 4, single pass
        ui_in = 8'h03; uio_in = 8'h0D;
        cyc(1);
        ui_in = 8'h0B;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            seq4 = {seq4[2:0], if1.uo_out[0]};
            cnt += int'(if1.uo_out[1]);
        end
        cyc(1);
        chk("t2_tx_seq", seq4, 4'b1101);
        chk("t2_busy_cycles", cnt, 4);
        chk("t2_done_bus", if1.uo_out[2:1], 2'b10);
        $display("[t2] 0D len4: tx=%b busy=%0d done=%b", seq4, cnt, if1.uo_out[2]);
        cyc(12);

        // T3: 0xA5 len 8 with repeat, then drop repeat mid-pass
        ui_in = 8'h17; uio_in = 8'hA5;
        cyc(1);
        ui_in = 8'h1F;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            seq16 = {seq16[14:0], if1.uo_out[0]};
            cnt += int'(if1.uo_out[2]);
        end
        chk("t3_tx_repeat", seq16, 16'hA5A5);
        chk("t3_no_done", cnt, 0);
        cyc(3);
        ui_in = 8'h0F;
        dc = 0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (if1.uo_out[2] && dc == 0) dc = i;
            cnt += int'(if1.uo_out[2]);
        end
        chk("t3_done_cycle", dc, 6);
        chk("t3_done_count", cnt, 1);
        $display("[t3] A5 repeat: tx=%h done_after=%0d pulses=%0d", seq16, dc, cnt);
        cyc(20);

        // T4: abort at bit index 4, then restart
        ui_in = 8'h07; uio_in = 8'hA5;
        cyc(1);
        ui_in = 8'h0F;
        cyc(4);
        chk("t4_idx_before_abort", if1.uo_out[5:3], 3'd4);
        ui_in = 8'h2F;
        cyc(1);
        chk("t4_after_abort", if1.uo_out[2:0], 3'b000);
        ui_in = 8'h07;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            cnt += int'(if1.uo_out[2]) + int'(if3.uo_out[2]);
        end
        chk("t4_no_done", cnt, 0);
        ui_in = 8'h0F;
        cyc(1);
        chk("t4_restart", if1.uo_out[5:0], 6'b111011);
        $display("[t4] abort at idx4, restart idx=%0d tx=%b", if1.uo_out[5:3], if1.uo_out[0]);
        cyc(30);

        // T5: start re-pulsed during SEND and DONE is ignored
        ui_in = 8'h03; uio_in = 8'h0D;
        cyc(1);
        ui_in = 8'h0B;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            seq4 = {seq4[2:0], if1.uo_out[0]};
            if (i == 0) ui_in = 8'h03;
            if (i == 1) ui_in = 8'h0B;
            if (i == 3) ui_in = 8'h03;
        end
        chk("t5_tx_seq", seq4, 4'b1101);
        cyc(1);
        chk("t5_done", if1.uo_out[2], 1'b1);
        ui_in = 8'h0B;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            cnt += int'(if1.uo_out[1]);
        end
        chk("t5_ignored_in_done", cnt, 0);
        cyc(12);
        ui_in = 8'h03;
        cyc(1);
        ui_in = 8'h0B;
        cyc(1);
        chk("t5_fresh_start", if1.uo_out[1:0], 2'b11);
        $display("[t5] re-pulse ignored: tx=%b, fresh start busy=%b", seq4, if1.uo_out[1]);
        cyc(14);

        // T6: three clocks per bit, then reset mid-frame
        ui_in = 8'h03; uio_in = 8'h0D;
        cyc(1);
        ui_in = 8'h0B;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seq12 = {seq12[10:0], if3.uo_out[0]};
            cnt += int'(if3.uo_out[1]);
        end
        cyc(1);
        chk("t6_tx_seq", seq12, 12'b111111000111);
        chk("t6_busy_cycles", cnt, 12);
        chk("t6_done_bus", if3.uo_out[2:1], 2'b10);
        cyc(3);
        ui_in = 8'h03;
        cyc(1);
        ui_in = 8'h0B;
        cyc(5);
        chk("t6_busy_before_reset", if3.uo_out[1], 1'b1);
        rst_n = 1'b0;
        cyc(1);
        chk("t6_reset_mid", if3.uo_out, 8'h00);
        rst_n = 1'b1;
        cyc(2);
        chk("t6_no_restart", if3.uo_out, 8'h00);
        $display("[t6] cpb3: tx=%b busy=%0d, reset mid-frame uo=%h", seq12, cnt, if3.uo_out);

        // Random traffic checked by the model
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] u;
            u = ui_in;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0)  u[3] = ~u[3];
            if ($urandom_range(0, 29) == 0) u[4] = ~u[4];
            u[5] = ($urandom_range(0, 39) == 0);
            if (!u[3]) u[2:0] = 3'($urandom_range(0, 7));
            u[7:6] = 2'($urandom_range(0, 3));
            ui_in  = u;
            uio_in = 8'($urandom_range(0, 255));
            cyc(1);
            cnt += int'(if1.uo_out[2]);
        end
        $display("[rand] 3000 cycles, cpb1 done pulses=%0d", cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
